// File: rtl/line_window_gen.sv
// Raster-stream to KxK sliding-window generator feeding the convolution PE.
// Optional start-of-frame input enabled by defining LINE_WINDOW_SOF_EN.
module line_window_gen #(
    parameter int KERNEL_SIZE    = 3,
    parameter int PX_SIZE        = 8,
    parameter int INPUT_CHANNELS = 1,
    parameter int IMG_WIDTH      = 32,
    parameter int IMG_HEIGHT     = 32
) (
    input  logic                                                               clk,
    input  logic                                                               rst,
    input  logic                                                               in_valid,
`ifdef LINE_WINDOW_SOF_EN
    input  logic                                                               in_sof,
`endif
    output logic                                                               in_ready,
    input  logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0]                             in_px,
    output logic                                                               out_valid,
    input  logic                                                               out_ready,
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] window,
    output logic [$clog2(IMG_WIDTH)-1:0]                                       out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0]                                      out_y,
    output logic                                                               out_last
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    typedef logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0] pixel_t;
    typedef pixel_t [KERNEL_SIZE-1:0]               column_t;
    typedef column_t [KERNEL_SIZE-1:0]              win_t;

    pixel_t        lb_mem [KERNEL_SIZE-1][IMG_WIDTH];
    pixel_t        lb_rd  [KERNEL_SIZE-1];
    win_t          win_sr;
    win_t          sr_next;
    logic [XW-1:0] col;
    logic [XW-1:0] pos_col;
    logic [YW-1:0] row;
    logic [YW-1:0] pos_row;
    logic          accept;
    logic          emit;
    logic          at_last_col;
    logic          at_last_row;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A start-of-frame pixel overrides the counters so it lands at (0,0).
`ifdef LINE_WINDOW_SOF_EN
    assign pos_col = in_sof ? '0 : col;
    assign pos_row = in_sof ? '0 : row;
`else
    assign pos_col = col;
    assign pos_row = row;
`endif

    assign at_last_col = (pos_col == XW'(IMG_WIDTH - 1));
    assign at_last_row = (pos_row == YW'(IMG_HEIGHT - 1));
    assign emit        = (pos_col >= XW'(KERNEL_SIZE - 1)) && (pos_row >= YW'(KERNEL_SIZE - 1));

    always_comb begin
        for (int k = 0; k < KERNEL_SIZE - 1; k++) begin
            lb_rd[k] = lb_mem[k][pos_col];
        end
    end

    // Buffer k holds the line k+1 rows above the incoming one; data ripples down a buffer per line.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_mem[0][pos_col] <= in_px;
            for (int k = 1; k < KERNEL_SIZE - 1; k++) begin
                lb_mem[k][pos_col] <= lb_rd[k-1];
            end
        end
    end

    // New rightmost column: oldest line on top, live pixel at the bottom.
    always_comb begin
        sr_next = win_sr;
        for (int x = 0; x < KERNEL_SIZE - 1; x++) begin
            sr_next[x] = win_sr[x+1];
        end
        for (int y = 0; y < KERNEL_SIZE - 1; y++) begin
            sr_next[KERNEL_SIZE-1][y] = lb_rd[KERNEL_SIZE-2-y];
        end
        sr_next[KERNEL_SIZE-1][KERNEL_SIZE-1] = in_px;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            win_sr    <= '0;
            out_valid <= 1'b0;
            window    <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                win_sr <= sr_next;
                if (at_last_col) begin
                    col <= '0;
                    row <= at_last_row ? '0 : pos_row + 1'b1;
                end else begin
                    col <= pos_col + 1'b1;
                    row <= pos_row;
                end
            end
            if (accept && emit) begin
                out_valid <= 1'b1;
                window    <= sr_next;
                out_x     <= pos_col - XW'(KERNEL_SIZE - 1);
                out_y     <= pos_row - YW'(KERNEL_SIZE - 1);
                out_last  <= at_last_col && at_last_row;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_window_gen.sv
// Bench for line_window_gen: a 4x4 single-channel instance and an 8x5 three-channel instance,
// both checked against a software sliding-window scoreboard.
module tb_line_window_gen;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    always #5 clk = ~clk;

    // 4x4, K=3, C=1 instance
    logic                        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [0:0][7:0]             a_in_px;
    logic [2:0][2:0][0:0][7:0]   a_window;
    logic [1:0]                  a_out_x, a_out_y;
    // 8x5, K=3, C=3 instance
    logic                        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [2:0][7:0]             b_in_px;
    logic [2:0][2:0][2:0][7:0]   b_window;
    logic [2:0]                  b_out_x, b_out_y;
`ifdef LINE_WINDOW_SOF_EN
    logic                        a_in_sof, b_in_sof;
`endif

    line_window_gen #(.KERNEL_SIZE(3), .PX_SIZE(8), .INPUT_CHANNELS(1), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid),
`ifdef LINE_WINDOW_SOF_EN
        .in_sof(a_in_sof),
`endif
        .in_ready(a_in_ready), .in_px(a_in_px), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .window(a_window), .out_x(a_out_x), .out_y(a_out_y), .out_last(a_out_last));

    line_window_gen #(.KERNEL_SIZE(3), .PX_SIZE(8), .INPUT_CHANNELS(3), .IMG_WIDTH(8), .IMG_HEIGHT(5)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid),
`ifdef LINE_WINDOW_SOF_EN
        .in_sof(b_in_sof),
`endif
        .in_ready(b_in_ready), .in_px(b_in_px), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .window(b_window), .out_x(b_out_x), .out_y(b_out_y), .out_last(b_out_last));

    typedef struct {
        logic [1:0]                x;
        logic [1:0]                y;
        logic                      last;
        logic [2:0][2:0][0:0][7:0] w;
    } win_a_t;

    typedef struct {
        logic [2:0]                x;
        logic [2:0]                y;
        logic                      last;
        logic [2:0][2:0][2:0][7:0] w;
    } win_b_t;

    win_a_t          a_q[$];
    win_a_t          a_seen[$];
    int              a_pos;
    logic [7:0]      a_img[4][4];
    win_b_t          b_q[$];
    win_b_t          b_seen[$];
    int              b_pos;
    logic [2:0][7:0] b_img[5][8];

    function automatic logic [2:0][2:0][0:0][7:0] ramp_window(input int base);
        logic [2:0][2:0][0:0][7:0] w;
        for (int x = 0; x < 3; x++)
            for (int y = 0; y < 3; y++)
                w[x][y][0] = 8'(base + 4 * y + x);
        return w;
    endfunction

    task automatic clear_models();
        a_q.delete();
        a_seen.delete();
        a_pos = 0;
        b_q.delete();
        b_seen.delete();
        b_pos = 0;
    endtask

    // One clock of dut_a: drive, sample, advance, then update the scoreboard.
    task automatic a_cycle(input logic v, input logic [7:0] px, input logic rdy, input logic sof, output logic acc);
        win_a_t got, e;
        logic   cons;
        int     c, r;
        a_in_valid  = v;
        a_in_px[0]  = px;
        a_out_ready = rdy;
`ifdef LINE_WINDOW_SOF_EN
        a_in_sof    = sof;
`endif
        #1;
        acc      = v && a_in_ready;
        cons     = a_out_valid && rdy;
        got.x    = a_out_x;
        got.y    = a_out_y;
        got.last = a_out_last;
        got.w    = a_window;
        @(posedge clk);
        @(negedge clk);
        if (acc) begin
            if (sof) a_pos = 0;
            c = a_pos % 4;
            r = a_pos / 4;
            a_img[r][c] = px;
            if (c >= 2 && r >= 2) begin
                e.x    = 2'(c - 2);
                e.y    = 2'(r - 2);
                e.last = (c == 3 && r == 3);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.w[i][j][0] = a_img[r - 2 + j][c - 2 + i];
                a_q.push_back(e);
            end
            a_pos = (a_pos + 1) % 16;
        end
        if (cons) begin
            a_seen.push_back(got);
            total++;
            if (a_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL a_window_order: got unexpected window at (%0d,%0d), expected none", got.x, got.y);
            end else begin
                e = a_q.pop_front();
                if (got.w !== e.w || got.x !== e.x || got.y !== e.y || got.last !== e.last) begin
                    bad++;
                    $display("[TB] FAIL a_window: got x=%0d y=%0d last=%0b w=%h, expected x=%0d y=%0d last=%0b w=%h",
                             got.x, got.y, got.last, got.w, e.x, e.y, e.last, e.w);
                end
            end
        end
    endtask

    task automatic b_cycle(input logic v, input logic [2:0][7:0] px, input logic rdy, output logic acc);
        win_b_t got, e;
        logic   cons;
        int     c, r;
        b_in_valid  = v;
        b_in_px     = px;
        b_out_ready = rdy;
        #1;
        acc      = v && b_in_ready;
        cons     = b_out_valid && rdy;
        got.x    = b_out_x;
        got.y    = b_out_y;
        got.last = b_out_last;
        got.w    = b_window;
        @(posedge clk);
        @(negedge clk);
        if (acc) begin
            c = b_pos % 8;
            r = b_pos / 8;
            b_img[r][c] = px;
            if (c >= 2 && r >= 2) begin
                e.x    = 3'(c - 2);
                e.y    = 3'(r - 2);
                e.last = (c == 7 && r == 4);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.w[i][j] = b_img[r - 2 + j][c - 2 + i];
                b_q.push_back(e);
            end
            b_pos = (b_pos + 1) % 40;
        end
        if (cons) begin
            b_seen.push_back(got);
            total++;
            if (b_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL b_window_order: got unexpected window at (%0d,%0d), expected none", got.x, got.y);
            end else begin
                e = b_q.pop_front();
                if (got.w !== e.w || got.x !== e.x || got.y !== e.y || got.last !== e.last) begin
                    bad++;
                    $display("[TB] FAIL b_window: got x=%0d y=%0d last=%0b w=%h, expected x=%0d y=%0d last=%0b w=%h",
                             got.x, got.y, got.last, got.w, e.x, e.y, e.last, e.w);
                end
            end
        end
    endtask

    task automatic a_drain(input int n);
        logic acc;
        for (int i = 0; i < n; i++) a_cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    endtask

    task automatic a_frame(input int base, input logic sof_first);
        logic acc;
        for (int p = 0; p < 16; p++) a_cycle(1'b1, 8'(base + p), 1'b1, sof_first && p == 0, acc);
    endtask

    task automatic a_expect_done(input string name, input int count);
        total++;
        if (a_seen.size() != count || a_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s_count: got %0d windows (%0d still expected), expected %0d", name, a_seen.size(), a_q.size(), count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_px = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_px = '0; b_out_ready = 1'b0;
`ifdef LINE_WINDOW_SOF_EN
        a_in_sof = 1'b0; b_in_sof = 1'b0;
`endif
        repeat (2) @(negedge clk);
        total++;
        if (a_out_valid !== 1'b0 || a_out_last !== 1'b0 || a_window !== '0 || a_out_x !== 2'd0 || a_out_y !== 2'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got valid=%b last=%b x=%0d y=%0d w=%h, expected all zero",
                     a_out_valid, a_out_last, a_out_x, a_out_y, a_window);
        end
        total++;
        if (a_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ready: got a_in_ready=%b b_out_valid=%b, expected 1 and 0", a_in_ready, b_out_valid);
        end
        rst = 1'b0;
        clear_models();
    endtask

    task automatic test_geometry();
        logic acc;
        a_seen.delete();
        for (int p = 0; p < 16; p++) begin
            a_cycle(1'b1, 8'(p), 1'b1, 1'b0, acc);
            if (p == 9) begin
                total++;
                if (a_out_valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL early_window: got out_valid=%b after pixel 9, expected 0", a_out_valid);
                end
            end
            if (p == 10) begin
                total++;
                if (a_out_valid !== 1'b1 || a_window !== ramp_window(0)) begin
                    bad++;
                    $display("[TB] FAIL first_window: got valid=%b w=%h, expected 1 w=%h", a_out_valid, a_window, ramp_window(0));
                end
            end
        end
        a_drain(3);
        a_expect_done("geometry", 4);
        if (a_seen.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (a_seen[k].x !== 2'(k % 2) || a_seen[k].y !== 2'(k / 2) || a_seen[k].last !== (k == 3)) begin
                    bad++;
                    $display("[TB] FAIL geometry_pos%0d: got (%0d,%0d) last=%b, expected (%0d,%0d) last=%b",
                             k, a_seen[k].x, a_seen[k].y, a_seen[k].last, k % 2, k / 2, k == 3);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic                      acc, rdy, stalled;
        int                        p, stall;
        logic [2:0][2:0][0:0][7:0] snap;
        a_seen.delete();
        p = 0; stall = 0; stalled = 1'b0; snap = '0;
        for (int cyc = 0; cyc < 100 && p < 16; cyc++) begin
            if (!stalled && a_out_valid) begin
                stalled = 1'b1;
                stall   = 5;
                snap    = a_window;
            end
            rdy = (stall == 0);
            a_cycle(1'b1, 8'(p), rdy, 1'b0, acc);
            if (acc) p++;
            if (stall > 0) begin
                stall--;
                total++;
                if (a_out_valid !== 1'b1 || a_window !== snap || a_in_ready !== 1'b0 || acc) begin
                    bad++;
                    $display("[TB] FAIL stall_hold: got valid=%b in_ready=%b acc=%b w=%h, expected 1 0 0 w=%h",
                             a_out_valid, a_in_ready, acc, a_window, snap);
                end
            end
        end
        total++;
        if (p != 16 || !stalled) begin
            bad++;
            $display("[TB] FAIL backpressure_timeout: got %0d pixels accepted stalled=%b, expected 16 and 1", p, stalled);
        end
        a_drain(3);
        a_expect_done("backpressure", 4);
    endtask

    task automatic test_back_to_back();
        a_seen.delete();
        a_frame(0, 1'b0);
        a_frame(100, 1'b0);
        a_drain(3);
        a_expect_done("back_to_back", 8);
        if (a_seen.size() == 8) begin
            total++;
            if (a_seen[4].w !== ramp_window(100) || a_seen[4].x !== 2'd0 || a_seen[4].y !== 2'd0) begin
                bad++;
                $display("[TB] FAIL frame2_first: got (%0d,%0d) w=%h, expected (0,0) w=%h",
                         a_seen[4].x, a_seen[4].y, a_seen[4].w, ramp_window(100));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic acc;
        int   cut [2] = '{7, 11};
        for (int t = 0; t < 2; t++) begin
            for (int p = 0; p < cut[t]; p++) a_cycle(1'b1, 8'(50 + p), 1'b1, 1'b0, acc);
            rst = 1'b1;
            #1;
            total++;
            if (a_out_valid !== 1'b0 || a_window !== '0 || a_out_x !== 2'd0 || a_out_y !== 2'd0) begin
                bad++;
                $display("[TB] FAIL reset_mid%0d: got valid=%b x=%0d y=%0d w=%h, expected all zero",
                         cut[t], a_out_valid, a_out_x, a_out_y, a_window);
            end
            @(negedge clk);
            rst = 1'b0;
            clear_models();
            a_frame(0, 1'b0);
            a_drain(3);
            a_expect_done("reset_mid", 4);
            if (a_seen.size() == 4) begin
                total++;
                if (a_seen[0].w !== ramp_window(0)) begin
                    bad++;
                    $display("[TB] FAIL reset_mid_first: got w=%h, expected w=%h", a_seen[0].w, ramp_window(0));
                end
            end
        end
    endtask

    task automatic test_random_stalls();
        logic                      acc, v, rdy, hold;
        logic [2:0][7:0]           px;
        logic [2:0][2:0][2:0][7:0] snap_w;
        logic [2:0]                snap_x, snap_y;
        int                        p;
        b_seen.delete();
        p = 0;
        for (int cyc = 0; cyc < 2000 && p < 40; cyc++) begin
            v      = ($urandom_range(0, 3) != 0);
            rdy    = ($urandom_range(0, 2) != 0);
            px     = 24'($urandom);
            hold   = b_out_valid && !rdy;
            snap_w = b_window;
            snap_x = b_out_x;
            snap_y = b_out_y;
            b_cycle(v, px, rdy, acc);
            if (acc) p++;
            if (hold) begin
                total++;
                if (acc || b_out_valid !== 1'b1 || b_window !== snap_w || b_out_x !== snap_x || b_out_y !== snap_y) begin
                    bad++;
                    $display("[TB] FAIL random_hold: got acc=%b valid=%b x=%0d y=%0d, expected 0 1 x=%0d y=%0d, window stable=%b",
                             acc, b_out_valid, b_out_x, b_out_y, snap_x, snap_y, b_window === snap_w);
                end
            end
        end
        for (int i = 0; i < 3; i++) b_cycle(1'b0, '0, 1'b1, acc);
        total++;
        if (p != 40 || b_seen.size() != 18 || b_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL random_count: got %0d pixels %0d windows (%0d pending), expected 40 18 0", p, b_seen.size(), b_q.size());
        end
    endtask

`ifdef LINE_WINDOW_SOF_EN
    task automatic test_sof();
        logic acc;
        a_seen.delete();
        for (int p = 0; p < 6; p++) a_cycle(1'b1, 8'(200 + p), 1'b1, 1'b0, acc);
        a_frame(0, 1'b1);
        a_drain(3);
        a_expect_done("sof", 4);
        if (a_seen.size() == 4) begin
            total++;
            if (a_seen[0].x !== 2'd0 || a_seen[0].y !== 2'd0 || a_seen[0].w !== ramp_window(0)) begin
                bad++;
                $display("[TB] FAIL sof_first: got (%0d,%0d) w=%h, expected (0,0) w=%h",
                         a_seen[0].x, a_seen[0].y, a_seen[0].w, ramp_window(0));
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clk   = 1'b0;
        rst   = 1'b1;
        total = 0;
        bad   = 0;
        test_reset();
        test_geometry();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random_stalls();
`ifdef LINE_WINDOW_SOF_EN
        test_sof();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_window_gen.md
Name: line_window_gen

Overview:
- Upstream feeder for the convolution processing element.
- Accepts a raster-order pixel stream, one pixel per handshake, all channels in parallel.
- Holds KERNEL_SIZE-1 line buffers plus a KxK shift window.
- Emits one registered KxK window per valid output position ("valid" convolution, no padding), laid out exactly as the processing element's image input.

Parameters:
- KERNEL_SIZE, 3, window width and height (square)
- PX_SIZE, 8, bits per channel sample
- INPUT_CHANNELS, 1, channels per pixel
- IMG_WIDTH, 32, pixels per line; must be >= KERNEL_SIZE
- IMG_HEIGHT, 32, lines per frame; must be >= KERNEL_SIZE

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_px is valid
- in_ready  output  1  block can accept in_px this cycle
- in_px  input  [INPUT_CHANNELS-1:0][PX_SIZE-1:0]  raster pixel
- out_valid  output  1  window and coordinates are valid
- out_ready  input  1  consumer accepts window
- window  output  [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0]  index [x][y][c]; x = column offset (0 = leftmost), y = row offset (0 = topmost)
- out_x  output  $clog2(IMG_WIDTH)  column of the window's top-left pixel
- out_y  output  $clog2(IMG_HEIGHT)  row of the window's top-left pixel
- out_last  output  1  window is the final one of the frame

Behaviour:
- Reset values:
  - out_valid = 0, out_last = 0, window = 0, out_x = 0, out_y = 0.
  - Column and row counters = 0.
  - Line buffer RAM contents are not reset; stale data is never emitted (see the suppression rule below).
- Handshake:
  - A pixel is accepted when in_valid && in_ready.
  - A window is consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is a one-entry output register; full throughput is one pixel per cycle when out_ready is held high.
- On each accepted pixel at position (col, row):
  - Each line buffer k is read at col, and its output is shifted into line buffer k+1. Line buffer 0 is written with in_px.
  - The window shifts one column left. The new rightmost column is filled top to bottom from the line buffer outputs (oldest row at y = 0), with in_px at y = KERNEL_SIZE-1.
  - col increments. At IMG_WIDTH-1, col wraps to 0 and row increments. At (IMG_WIDTH-1, IMG_HEIGHT-1), both counters wrap to 0 and a new frame begins.
- Window generation:
  - Accepting a pixel with col >= KERNEL_SIZE-1 and row >= KERNEL_SIZE-1 loads the output register on the same edge.
  - out_valid is high the following cycle (latency 1).
  - out_x = col-(KERNEL_SIZE-1), out_y = row-(KERNEL_SIZE-1).
  - out_last = 1 only for the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1).
- Suppression:
  - Pixels with col < KERNEL_SIZE-1 or row < KERNEL_SIZE-1 produce no window.
  - This covers columns left over from the previous line and rows left over from the previous frame.
- Stall: while out_valid && !out_ready, window, out_x, out_y and out_last hold stable, and in_ready = 0.
- Simultaneous consume and accept: the output register reloads if the new pixel yields a window; otherwise out_valid falls.
- Window count: exactly (IMG_WIDTH-KERNEL_SIZE+1)*(IMG_HEIGHT-KERNEL_SIZE+1) windows per frame, in raster order. Back-to-back frames run with no bubble.
- Reset mid-frame: all outputs and counters return to their reset values immediately. The next accepted pixel is treated as (0,0).

Optional Feature:
- Macro: LINE_WINDOW_SOF_EN
- Defined:
  - Adds input port in_sof (1 bit).
  - An accepted pixel with in_sof = 1 is treated as position (0,0) regardless of the counters. Counters then continue from (1,0).
  - If in_sof arrives mid-frame, the partial frame is abandoned: no further windows from it. A window already in the output register is still delivered.
- Not defined: no in_sof port; position is derived purely from the counters.

Test Plan:
- Stream geometry: IMG_WIDTH = 4, IMG_HEIGHT = 4, KERNEL_SIZE = 3, C = 1, in_px = 4*row+col, out_ready = 1.
  - Exactly 4 windows at (0,0), (1,0), (0,1), (1,1).
  - First window has window[x][y] = 4*y+x, i.e. 0,1,2,4,5,6,8,9,10, valid one cycle after pixel 10 is accepted.
  - out_last is set only on the fourth window, at (1,1).
- Backpressure: same stream with out_ready held low for 5 cycles when the first window appears.
  - out_valid stays high and window stays unchanged; in_ready = 0.
  - After release, no windows are lost or duplicated.
- Back-to-back frames: two frames, the second with in_px = 100+4*row+col.
  - 8 windows total.
  - Second frame's first window is 100,101,102,104,105,106,108,109,110; no window contains first-frame data.
- Reset mid-frame: assert rst after 7 pixels, then send a full frame.
  - out_valid = 0 during reset.
  - Afterwards, 4 correct windows, matching the first scenario.
- Random stalls: random in_valid and out_ready, IMG_WIDTH = 8, IMG_HEIGHT = 5, INPUT_CHANNELS = 3.
  - Scoreboard matches a software sliding window.
  - 18 windows with correct out_x and out_y.
- With LINE_WINDOW_SOF_EN defined: send 6 pixels, then in_sof with a full frame.
  - Exactly 4 windows, all from the new frame; first window at (0,0).
